audio_init_sequencer: RTL and testbench

Parametrised successor to the single-flag codec initializer. It walks a table of NUM_REGS configuration words and pushes each one, one at a time, to the serial-bus (I2C) write master through a valid/ready handshake. Each write completes through a done/ack-error response; failed or timed-out writes are retried up to a limit. It drives the same `init` flag to the audio datapath (high until configuration succeeds) and adds done/error status plus a software re-initialize request.

---
 rtl/audio_pkg.sv | 17 +
 rtl/audio_init_sequencer_if.sv | 18 +
 rtl/audio_init_sequencer_timeout.sv | 24 ++
 rtl/audio_init_sequencer.sv | 119 +++++++++++
 tb/tb_audio_init_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared types and default sizing for the codec init sequencer.
package audio_pkg;

    typedef enum logic [2:0] {
        ST_INITIALIZE = 3'd0,
        ST_LOAD       = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_WAIT       = 3'd3,
        ST_NEXT       = 3'd4,
        ST_READY      = 3'd5,
        ST_FAIL       = 3'd6
    } init_state_t;

    localparam int AUDIO_NUM_REGS = 10;
    localparam int AUDIO_CFG_W    = 24;

endpackage

// File: rtl/audio_init_sequencer_if.sv
// Write channel between the init sequencer and the serial-bus write master.
// Handshake: a request transfers on the cycle wr_valid && wr_ready; wr_valid and
// wr_data hold until then. wr_done is a one-cycle completion pulse and wr_err is
// only meaningful while wr_done is high.
interface audio_init_sequencer_if #(
    parameter int DATA_W = 24
) ();
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              wr_done;
    logic              wr_err;

    modport master (output wr_valid, output wr_data,
                    input  wr_ready, input  wr_done, input wr_err);
    modport slave  (input  wr_valid, input  wr_data,
                    output wr_ready, output wr_done, output wr_err);
endinterface

// File: rtl/audio_init_sequencer_timeout.sv
// Clearable up-counter that flags when TIMEOUT_CYC-1 is reached and holds there.
module init_timeout_counter #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic Clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] count_q;

    assign terminal = (count_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge Clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && !terminal) begin
            count_q <= count_q + 1'b1;
        end
    end
endmodule

// File: rtl/audio_init_sequencer.sv
// Walks the codec configuration table, writing each word over the serial-bus
// write channel with per-word retry, and reports init / done / error status.
module audio_init_sequencer
    import audio_pkg::*;
#(
    parameter  int NUM_REGS    = AUDIO_NUM_REGS,
    parameter  int DATA_W      = AUDIO_CFG_W,
    parameter  int TIMEOUT_CYC = 100000,
    parameter  int MAX_RETRY   = 3,
    localparam int IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                    Clk,
    input  logic                    reset,
    input  logic                    reinit,
    output logic [IDX_W-1:0]        cfg_idx,
    input  logic [DATA_W-1:0]       cfg_word,
    audio_init_sequencer_if.master  wr_bus,
    output logic                    init,
    output logic                    init_done,
    output logic                    init_error,
    output logic [IDX_W-1:0]        fail_idx,
    output init_state_t             state_dbg
);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    init_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  fail_idx_q;
    logic [RETRY_W-1:0] retry_q;
    logic [DATA_W-1:0] data_q;
    logic              attempt_fail;
    logic              tmo_tc;
    logic              last_word;
    logic              retry_left;

    assign last_word  = (idx_q == IDX_W'(NUM_REGS - 1));
    assign retry_left = (int'(retry_q) < MAX_RETRY);

    init_timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .Clk      (Clk),
        .reset    (reset),
        .clear    (state_q == ST_ISSUE),
        .enable   (state_q == ST_WAIT),
        .terminal (tmo_tc)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= ST_INITIALIZE;
        end else begin
            state_q <= state_d;
        end
    end

    // A completion pulse takes priority over a coincident timeout.
    always_comb begin
        state_d      = state_q;
        attempt_fail = 1'b0;
        case (state_q)
            ST_INITIALIZE: state_d = ST_LOAD;
            ST_LOAD:       state_d = ST_ISSUE;
            ST_ISSUE:      if (wr_bus.wr_ready) state_d = ST_WAIT;
            ST_WAIT: begin
                if (wr_bus.wr_done) begin
                    if (wr_bus.wr_err) attempt_fail = 1'b1;
                    else               state_d = ST_NEXT;
                end else if (tmo_tc) begin
                    attempt_fail = 1'b1;
                end
                if (attempt_fail) state_d = retry_left ? ST_LOAD : ST_FAIL;
            end
            ST_NEXT:       state_d = last_word ? ST_READY : ST_LOAD;
            ST_READY,
            ST_FAIL:       if (reinit) state_d = ST_INITIALIZE;
            default:       state_d = ST_INITIALIZE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            idx_q      <= '0;
            retry_q    <= '0;
            data_q     <= '0;
            fail_idx_q <= '0;
        end else begin
            case (state_q)
                ST_INITIALIZE: begin
                    idx_q   <= '0;
                    retry_q <= '0;
                end
                ST_LOAD: data_q <= cfg_word;
                ST_WAIT: begin
                    if (attempt_fail) begin
                        if (retry_left) retry_q    <= retry_q + 1'b1;
                        else            fail_idx_q <= idx_q;
                    end
                end
                ST_NEXT: begin
                    if (!last_word) begin
                        idx_q   <= idx_q + 1'b1;
                        retry_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cfg_idx         = idx_q;
    assign fail_idx        = fail_idx_q;
    assign wr_bus.wr_valid = (state_q == ST_ISSUE);
    assign wr_bus.wr_data  = data_q;
    assign init            = (state_q != ST_READY);
    assign init_done       = (state_q == ST_READY);
    assign init_error      = (state_q == ST_FAIL);
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_audio_init_sequencer.sv
// Bench for audio_init_sequencer: a transaction-level model predicts the write
// order and the cycle at which status settles; a per-cycle monitor compares.
module tb_audio_init_sequencer;
    import audio_pkg::*;

    localparam int N  = 3;
    localparam int W  = 24;
    localparam int T  = 8;
    localparam int MR = 3;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic reset = 1'b1;
    logic reinit = 1'b0;
    always #5 Clk = ~Clk;

    logic [1:0]   cfg_idx;
    logic [1:0]   fail_idx;
    logic [W-1:0] cfg_word;
    logic         init, init_done, init_error;
    init_state_t  state_dbg;
    logic [W-1:0] rom [N];

    audio_init_sequencer_if #(.DATA_W(W)) bus ();

    assign cfg_word = (cfg_idx < 2'(N)) ? rom[cfg_idx] : '0;

    audio_init_sequencer #(
        .NUM_REGS(N), .DATA_W(W), .TIMEOUT_CYC(T), .MAX_RETRY(MR)
    ) dut (
        .Clk(Clk), .reset(reset), .reinit(reinit),
        .cfg_idx(cfg_idx), .cfg_word(cfg_word), .wr_bus(bus.master),
        .init(init), .init_done(init_done), .init_error(init_error),
        .fail_idx(fail_idx), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    int plan_r[$], plan_k[$], plan_d[$];   // kind: 0 ack, 1 nack, 2 no response
    int m_total;
    bit m_fail;
    int m_fail_idx;
    bit chk_on = 1'b0;
    int cyc = 0;
    int end_cyc = -1;
    bit prev_hold = 1'b0;
    logic [W-1:0] prev_data = '0;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic void pick(int mode, int idx, int retry,
                                 output int r, output int k, output int d);
        int v;
        r = 0; k = 0; d = 0;
        case (mode)
            0: begin
                r = $urandom_range(0, 3);
                d = $urandom_range(0, T - 1);
                v = $urandom_range(0, 99);
                k = (v < 70) ? 0 : (v < 85) ? 1 : 2;
            end
            2: if (idx == 1 && retry < 2) k = 1;
            3: if (idx == 2) k = 1;
            4: k = 2;
            5: d = T - 1;
            6: r = 20;
            default: ;
        endcase
    endfunction

    // Each attempt costs LOAD + (r+1) ISSUE + WAIT (d+1, or T on timeout),
    // plus one NEXT cycle on success; INITIALIZE adds one cycle up front.
    function automatic void build_model(int mode);
        int idx = 0, retry = 0, r, k, d;
        bit fin = 1'b0;
        plan_r.delete(); plan_k.delete(); plan_d.delete(); exp_q.delete();
        m_total = 1; m_fail = 1'b0; m_fail_idx = 0;
        while (!fin) begin
            pick(mode, idx, retry, r, k, d);
            plan_r.push_back(r); plan_k.push_back(k); plan_d.push_back(d);
            exp_q.push_back(rom[idx]);
            m_total += 2 + r + ((k == 2) ? T : d + 1);
            if (k == 0) begin
                m_total += 1;
                if (idx == N - 1) fin = 1'b1;
                else begin idx++; retry = 0; end
            end else if (retry < MR) begin
                retry++;
            end else begin
                m_fail = 1'b1; m_fail_idx = idx; fin = 1'b1;
            end
        end
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge Clk) begin
        if (chk_on) begin
            logic [2:0] exp3;
            exp3 = (cyc < m_total) ? 3'b100 : (m_fail ? 3'b101 : 3'b010);
            check("status", {init, init_done, init_error}, exp3);
            if (end_cyc < 0 && (init_done || init_error)) end_cyc = cyc;
            if (cyc >= m_total) check("idle_wr_valid", bus.wr_valid, 0);
            if (prev_hold) begin
                check("hold_valid", bus.wr_valid, 1);
                check("hold_data", bus.wr_data, prev_data);
            end
            if (bus.wr_valid && bus.wr_ready) begin
                if (exp_q.size() == 0) check("extra_write", 1, 0);
                else check("write_data", bus.wr_data, exp_q.pop_front());
            end
            prev_hold = bus.wr_valid && !bus.wr_ready;
            prev_data = bus.wr_data;
            cyc++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_master();
        for (int i = 0; i < plan_r.size(); i++) begin
            int g = 0;
            while (!bus.wr_valid && g < 60) begin step(); g++; end
            if (!bus.wr_valid) begin
                check("wait_valid", bus.wr_valid, 1);
                return;
            end
            repeat (plan_r[i]) step();
            bus.wr_ready = 1'b1;
            step();
            bus.wr_ready = 1'b0;
            if (plan_k[i] != 2) begin
                repeat (plan_d[i]) step();
                bus.wr_done = 1'b1;
                bus.wr_err  = (plan_k[i] == 1);
                step();
                bus.wr_done = 1'b0;
                bus.wr_err  = 1'b0;
            end
        end
    endtask

    task automatic run_scenario(int mode, bit use_reinit, bit mid_reinit,
                                bit stray, int lit_end);
        int g = 0;
        for (int i = 0; i < N; i++) rom[i] = W'($urandom);
        build_model(mode);
        if (use_reinit) begin
            reinit = 1'b1; step(); reinit = 1'b0;
        end else begin
            reset = 1'b1; step(); step(); reset = 1'b0;
        end
        cyc = 0; end_cyc = -1; prev_hold = 1'b0; chk_on = 1'b1;
        if (stray) begin
            bus.wr_done = 1'b1; bus.wr_err = 1'b1; step();
            bus.wr_done = 1'b0; bus.wr_err = 1'b0;
        end
        fork
            drive_master();
            begin
                if (mid_reinit) begin
                    repeat (5) step();
                    reinit = 1'b1; step(); reinit = 1'b0;
                end
            end
        join
        while (cyc < m_total + 3 && g < 2000) begin step(); g++; end
        chk_on = 1'b0;
        check("run_bounded", cyc >= m_total + 3, 1);
        check("writes_left", exp_q.size(), 0);
        check("end_cycle", end_cyc, m_total);
        if (lit_end > 0) check("end_literal", end_cyc, lit_end);
        if (m_fail) check("fail_idx", fail_idx, m_fail_idx);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t reached limit 500000", $time);
        $fatal(1);
    end

    initial begin
        int g;
        bus.wr_ready = 1'b0; bus.wr_done = 1'b0; bus.wr_err = 1'b0;
        for (int i = 0; i < N; i++) rom[i] = '0;
        repeat (3) step();
        check("rst_wr_valid", bus.wr_valid, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_init", init, 1);
        check("rst_init_done", init_done, 0);
        check("rst_init_error", init_error, 0);
        check("rst_cfg_idx", cfg_idx, 0);
        check("rst_fail_idx", fail_idx, 0);
        check("rst_state", state_dbg, ST_INITIALIZE);

        run_scenario(1, 0, 0, 0, 13);   // zero-wait master
        run_scenario(2, 0, 0, 0, 19);   // word 1 NACKed twice
        run_scenario(3, 0, 0, 0, 21);   // word 2 always NACKed -> FAIL
        run_scenario(4, 1, 0, 0, 41);   // never completes -> FAIL by timeout
        run_scenario(5, 1, 0, 0, 34);   // done coincides with terminal count
        run_scenario(6, 0, 0, 0, 73);   // ready held low 20 cycles
        run_scenario(1, 1, 1, 0, 13);   // reinit while busy is ignored

        // Reset while a write is outstanding, then a stray completion pulse.
        reset = 1'b1; step(); reset = 1'b0;
        g = 0;
        while (!bus.wr_valid && g < 20) begin step(); g++; end
        check("abort_issue", bus.wr_valid, 1);
        bus.wr_ready = 1'b1; step(); bus.wr_ready = 1'b0; step();
        check("abort_in_wait", state_dbg, ST_WAIT);
        reset = 1'b1; step();
        check("abort_wr_valid", bus.wr_valid, 0);
        check("abort_init", init, 1);
        check("abort_state", state_dbg, ST_INITIALIZE);
        bus.wr_done = 1'b1; step(); bus.wr_done = 1'b0;
        run_scenario(1, 0, 0, 1, 13);

        for (int s = 0; s < 8; s++) run_scenario(0, 1, s[0], 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
